ppu_quant: RTL and testbench

PPU_QUANT -- requirements
Module: ppu_quant

---
 rtl/ppu_quant_pkg.sv | 15 +
 rtl/define.svh | 7 +
 rtl/ppu_requant.sv | 37 +++
 rtl/ppu_quant.sv | 101 ++++++++++
 tb/tb_ppu_quant.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ppu_quant_pkg.sv
// Shared types and constants for the PPU requantize/pack path.
package ppu_quant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_SEND = 2'd2
  } ppu_state_e;

  localparam logic [7:0] ZERO_CODE   = 8'h80;
  localparam int         CLAMP_MIN   = -128;
  localparam int         CLAMP_MAX   = 127;
  localparam int         SHIFT_W_DEF = 5;

endpackage

// File: rtl/define.svh
// Global datapath width shared by the PPU blocks and their benches.
`ifndef PPU_DEFINE_SVH
`define PPU_DEFINE_SVH
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`endif

// File: rtl/ppu_requant.sv
// Combinational round-half-up shift, optional ReLU, int8 clamp and offset-binary encode.
// Define PPU_RELU_EN to force negative results to zero before clamping.
`include "define.svh"

module ppu_requant
  import ppu_quant_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic [`DATA_BITS-1:0] opsum,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [7:0]            code_o
);

  localparam int W = `DATA_BITS + 1;
  localparam logic signed [W-1:0] MAXV = W'(CLAMP_MAX);
  localparam logic signed [W-1:0] MINV = W'(CLAMP_MIN);

  logic signed [W-1:0] ext, rnd, sum, r;
  logic [7:0]          q;

  always_comb begin
    ext = {opsum[`DATA_BITS-1], opsum};
    rnd = '0;
    if (shift != '0) rnd = W'(1) << (shift - 1'b1);
    sum = ext + rnd;
    r   = sum >>> shift;
`ifdef PPU_RELU_EN
    if (r[W-1]) r = '0;
`endif
    if (r > MAXV)      q = 8'h7F;
    else if (r < MINV) q = 8'h80;
    else               q = r[7:0];
    code_o = q ^ ZERO_CODE;
  end

endmodule

// File: rtl/ppu_quant.sv
// PPU output stage: requantizes opsums to int8 and packs 1..4 bytes per ifmap word.
// Build with PPU_RELU_EN defined to clip negative activations to zero.
`include "define.svh"

module ppu_quant
  import ppu_quant_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ppu_en,
  input  logic [SHIFT_W-1:0]    i_shift,
  input  logic [1:0]            i_lanes,
  input  logic [`DATA_BITS-1:0] opsum,
  input  logic                  opsum_valid,
  input  logic                  opsum_last,
  output logic                  opsum_ready,
  output logic [`DATA_BITS-1:0] ifmap,
  output logic                  ifmap_valid,
  input  logic                  ifmap_ready
);

  ppu_state_e           state_q, state_d;
  logic [1:0]           lane_cnt_q, lane_cnt_d;
  logic                 last_flag_q, last_flag_d;
  logic [SHIFT_W-1:0]   cfg_shift_q, cfg_shift_d;
  logic [1:0]           cfg_lanes_q, cfg_lanes_d;
  logic [3:0][7:0]      word_q, word_d;
  logic                 opsum_ready_q, opsum_ready_d;
  logic                 ifmap_valid_q, ifmap_valid_d;
  logic [7:0]           code;
  logic                 hs;

  ppu_requant #(.SHIFT_W(SHIFT_W)) u_requant (
    .opsum  (opsum),
    .shift  (cfg_shift_q),
    .code_o (code)
  );

  always_comb begin
    hs          = opsum_valid && opsum_ready_q;
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    last_flag_d = last_flag_q;
    cfg_shift_d = cfg_shift_q;
    cfg_lanes_d = cfg_lanes_q;
    word_d      = word_q;
    case (state_q)
      ST_IDLE: if (ppu_en) begin
        cfg_shift_d = i_shift;
        cfg_lanes_d = i_lanes;
        state_d     = ST_PACK;
      end
      ST_PACK: if (hs) begin
        word_d[lane_cnt_q] = code;
        lane_cnt_d         = 2'(lane_cnt_q + 2'd1);
        if (lane_cnt_q == cfg_lanes_q || opsum_last) begin
          last_flag_d = opsum_last;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: if (ifmap_ready) begin
        word_d     = {4{ZERO_CODE}};
        lane_cnt_d = 2'd0;
        state_d    = last_flag_q ? ST_IDLE : ST_PACK;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered off the next state so they align with it.
    opsum_ready_d = (state_d == ST_PACK);
    ifmap_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lane_cnt_q    <= 2'd0;
      last_flag_q   <= 1'b0;
      cfg_shift_q   <= '0;
      cfg_lanes_q   <= 2'd0;
      word_q        <= {4{ZERO_CODE}};
      opsum_ready_q <= 1'b0;
      ifmap_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      last_flag_q   <= last_flag_d;
      cfg_shift_q   <= cfg_shift_d;
      cfg_lanes_q   <= cfg_lanes_d;
      word_q        <= word_d;
      opsum_ready_q <= opsum_ready_d;
      ifmap_valid_q <= ifmap_valid_d;
    end
  end

  assign opsum_ready = opsum_ready_q;
  assign ifmap_valid = ifmap_valid_q;
  assign ifmap       = word_q;

endmodule

// File: tb/tb_ppu_quant.sv
// Directed bench for ppu_quant with hand-computed expected words.
module tb_ppu_quant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ppu_en = 1'b0;
  logic [4:0]  i_shift = '0;
  logic [1:0]  i_lanes = '0;
  logic [31:0] opsum = '0;
  logic        opsum_valid = 1'b0;
  logic        opsum_last = 1'b0;
  logic        opsum_ready;
  logic [31:0] ifmap;
  logic        ifmap_valid;
  logic        ifmap_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  ppu_quant dut (
    .clk         (clk),
    .rst         (rst),
    .ppu_en      (ppu_en),
    .i_shift     (i_shift),
    .i_lanes     (i_lanes),
    .opsum       (opsum),
    .opsum_valid (opsum_valid),
    .opsum_last  (opsum_last),
    .opsum_ready (opsum_ready),
    .ifmap       (ifmap),
    .ifmap_valid (ifmap_valid),
    .ifmap_ready (ifmap_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic start_tile(input logic [4:0] sh, input logic [1:0] ln);
    ppu_en  = 1'b1;
    i_shift = sh;
    i_lanes = ln;
    @(posedge clk); #1;
    ppu_en  = 1'b0;
  endtask

  task automatic push(input logic [31:0] v, input logic last);
    chk("opsum_ready", {31'd0, opsum_ready}, 32'd1);
    opsum       = v;
    opsum_valid = 1'b1;
    opsum_last  = last;
    @(posedge clk); #1;
    opsum_valid = 1'b0;
    opsum_last  = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, {31'd0, ifmap_valid}, 32'd1);
    chk(tag, ifmap, exp);
  endtask

  task automatic accept();
    ifmap_ready = 1'b1;
    @(posedge clk); #1;
    ifmap_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, opsum_ready}, 32'd0);
    chk("rst_valid", {31'd0, ifmap_valid}, 32'd0);
    chk("rst_ifmap", ifmap, 32'h80808080);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full pack of four lanes, then back to IDLE.
    start_tile(5'd0, 2'd3);
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    push(32'd4, 1'b1);
    expect_word("pack", 32'h84838281);
    accept();
    chk("pack_idle_rdy", {31'd0, opsum_ready}, 32'd0);
    chk("pack_idle_vld", {31'd0, ifmap_valid}, 32'd0);

    // Rounding: (100+8)>>4 = 6; (-100+8)>>>4 = -6.
    start_tile(5'd4, 2'd0);
    push(32'd100, 1'b0);
    expect_word("round_pos", 32'h80808086);
    accept();
    push(-32'sd100, 1'b1);
`ifdef PPU_RELU_EN
    expect_word("round_neg", 32'h80808080);
`else
    expect_word("round_neg", 32'h8080807A);
`endif
    accept();

    // Saturation at the extremes of the 32-bit input.
    start_tile(5'd0, 2'd0);
    push(32'h7FFFFFFF, 1'b0);
    expect_word("sat_max", 32'h808080FF);
    accept();
    push(32'h80000000, 1'b1);
`ifdef PPU_RELU_EN
    expect_word("sat_min", 32'h80808080);
`else
    expect_word("sat_min", 32'h80808000);
`endif
    accept();

    // Clamp boundaries: 127, 128, -128, -129.
    start_tile(5'd0, 2'd3);
    push(32'd127, 1'b0);
    push(32'd128, 1'b0);
    push(-32'sd128, 1'b0);
    push(-32'sd129, 1'b1);
`ifdef PPU_RELU_EN
    expect_word("clamp_edge", 32'h8080FFFF);
`else
    expect_word("clamp_edge", 32'h0000FFFF);
`endif
    accept();

    // Maximum shift: (0x7FFFFFFF + 2^30) >>> 31 = 1.
    start_tile(5'd31, 2'd0);
    push(32'h7FFFFFFF, 1'b1);
    expect_word("shift31", 32'h80808081);
    accept();

    // Early last leaves unwritten lanes at the zero code.
    start_tile(5'd0, 2'd3);
    push(32'd5, 1'b0);
    push(32'd6, 1'b1);
    expect_word("early_last", 32'h80808685);
    accept();

    // Backpressure: word and handshake outputs hold while ready is low.
    start_tile(5'd0, 2'd1);
    push(32'd9, 1'b0);
    push(32'd10, 1'b1);
    expect_word("bp", 32'h80808A89);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_word", ifmap, 32'h80808A89);
      chk("bp_valid", {31'd0, ifmap_valid}, 32'd1);
      chk("bp_ready", {31'd0, opsum_ready}, 32'd0);
    end
    accept();

    // ppu_en mid-tile must not alter the latched shift or lane count.
    start_tile(5'd0, 2'd1);
    push(32'd1, 1'b0);
    ppu_en  = 1'b1;
    i_shift = 5'd4;
    i_lanes = 2'd3;
    @(posedge clk); #1;
    ppu_en  = 1'b0;
    push(32'd32, 1'b0);
    expect_word("cfg_hold", 32'h8080A081);
    accept();
    push(32'd7, 1'b1);
    expect_word("cfg_hold2", 32'h80808087);
    accept();

    // Reset mid-PACK discards the partial word.
    start_tile(5'd0, 2'd3);
    push(32'd7, 1'b0);
    push(32'd8, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, opsum_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, ifmap_valid}, 32'd0);
    chk("mid_rst_ifmap", ifmap, 32'h80808080);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, opsum_ready}, 32'd0);
    start_tile(5'd0, 2'd1);
    push(32'd3, 1'b0);
    push(32'd4, 1'b1);
    expect_word("post_rst", 32'h80808483);
    accept();
    chk("post_rst_done", {31'd0, ifmap_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
